regfile_multiport: RTL and testbench
====================================

Name: regfile_multiport

Overview:
- Parametrised successor to the single-write-port MIPS register file.
- Clocked, with NUM_READ combinational read ports and NUM_WRITE synchronous write ports.
- Register 0 is hardwired to zero. After reset, a sweep FSM clears the storage array, so the array can map to RAM without a per-entry reset.
- Sits between decode (read addresses) and writeback (write ports) in the pipelined datapath.

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 32, number of registers; must be a power of two and at least 2.
- ADDR_W, $clog2(DEPTH), register address width.
- NUM_READ, 2, number of read ports (1..4).
- NUM_WRITE, 1, number of write ports (1..2).

Ports:
- clk  input  1  clock, rising edge.
- rstN  input  1  asynchronous active-low reset.
- readReg  input  NUM_READ*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- readData  output  NUM_READ*DATA_W  read data; packed the same way as readReg.
- regWrite  input  NUM_WRITE  per-port write enable.
- writeReg  input  NUM_WRITE*ADDR_W  write addresses.
- writeData  input  NUM_WRITE*DATA_W  write data.
- ready  output  1  high once the clear sweep has completed.

Behaviour:
- Reset is asynchronous and active-low: rstN low forces the FSM to INIT, clearIdx to 0 and ready to 0 immediately, independent of clk.
- FSM states:
  - INIT: each clk writes 0 to entry clearIdx, then clearIdx increments. When clearIdx = DEPTH-1 is written, go to RUN on the next edge. INIT therefore lasts exactly DEPTH cycles after rstN deasserts.
  - RUN: ready=1. Normal operation. RUN is terminal until the next reset.
- ready is registered: 0 in INIT, 1 in RUN.
- Read path:
  - Combinational, zero latency.
  - readData[i] = 0 whenever readReg[i] = 0.
  - readData[i] = 0 in INIT, regardless of address.
- Write path:
  - At a rising clk in RUN, each port w with regWrite[w]=1 and writeReg[w]≠0 stores writeData[w].
  - Writes to register 0 are silently discarded.
  - regWrite is ignored in INIT: no storage change and no error.
- Simultaneous writes to the same non-zero address: the highest-numbered port wins.
- Read and write to the same address in the same cycle: without the bypass feature, the read returns the old value; the new value is visible from the next cycle.
- Reset mid-operation: contents are undefined until the sweep completes. No write issued in the cycle rstN falls takes effect.
- Parameter checks: an elaboration-time error is required for a non-power-of-two DEPTH, NUM_READ outside 1..4, or NUM_WRITE outside 1..2.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding in RUN.
  - If any port w has regWrite[w]=1 and writeReg[w]=readReg[i]≠0, then readData[i]=writeData[w] in the same cycle.
  - Forwarding follows the same highest-port-wins priority as storage.
- Undefined: no forwarding, and reads return the stored value.
- The register-0 rule and the INIT-returns-zero rule apply in both cases.

Decomposition:
- Shared package regfile_pkg:
  - FSM state enum (INIT, RUN).
  - Default width constants (DATA_W=32, DEPTH=32).
  - Function computing the winning write port for an address.
- One natural sub-module, regfile_read_port: a single read port containing the zero-register mux, the INIT gating and the optional bypass mux. It is instantiated NUM_READ times via generate.

Test Plan:
- Reset sweep: hold rstN low for 3 cycles, release → ready=0 for exactly 32 cycles, then 1. Every readReg reads 0x00000000 after ready rises.
- Basic write/read: in RUN, write reg 5 = 0xDEADBEEF → from the next cycle readData on both ports at address 5 = 0xDEADBEEF; address 6 reads 0.
- Zero register: write reg 0 = 0xFFFFFFFF → readData at address 0 = 0 on every port, in every subsequent cycle.
- Dual-write collision (NUM_WRITE=2): port0 writes reg 9 = 0x11111111 and port1 writes reg 9 = 0x22222222 in the same cycle → reg 9 reads 0x22222222.
- Same-cycle read/write of reg 7, old value 0xA, new value 0xB:
  - Without REGFILE_BYPASS_EN → readData = 0xA that cycle, 0xB the next.
  - With REGFILE_BYPASS_EN → 0xB in the same cycle.
- Mid-operation reset: write reg 3 = 0x1234, pulse rstN low asynchronously between edges → ready drops immediately. A write attempted during INIT is ignored, and reg 3 reads 0 after ready returns high.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multiport register file.
// Contents: FSM state enum, default geometry, write-port priority helper.
// Optional feature macro used by the slice: REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_DEPTH  = 32;
  localparam int unsigned MAX_READ   = 4;
  localparam int unsigned MAX_WRITE  = 2;
  localparam int unsigned WPORT_W    = 1;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic               hit;
    logic [WPORT_W-1:0] idx;
  } win_t;

  // Picks the winning write port from a per-port address-match mask:
  // the highest-numbered matching port wins.
  function automatic win_t win_port(input logic [MAX_WRITE-1:0] hit);
    win_t r;
    r.hit = |hit;
    r.idx = '0;
    for (int unsigned w = 0; w < MAX_WRITE; w++) begin
      if (hit[w]) r.idx = WPORT_W'(w);
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of regfile_multiport.
// Ports:
//   running - high once the clear sweep has completed (gates data to zero otherwise)
//   addr    - read address; address 0 always reads zero
//   stored  - array contents at addr
//   wr_en/wr_addr/wr_data - write-port view, present only with REGFILE_BYPASS_EN
//   data    - read data
// Macro REGFILE_BYPASS_EN: forward same-cycle write data to the read.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
`ifdef REGFILE_BYPASS_EN
  parameter int unsigned NUM_WRITE = 1,
`endif
  parameter int unsigned ADDR_W    = 5
) (
  input  logic                        running,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [DATA_W-1:0]           stored,
`ifdef REGFILE_BYPASS_EN
  input  logic [NUM_WRITE-1:0]        wr_en,
  input  logic [NUM_WRITE*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WRITE*DATA_W-1:0] wr_data,
`endif
  output logic [DATA_W-1:0]           data
);

  logic [DATA_W-1:0] fwd;

`ifdef REGFILE_BYPASS_EN
  logic [MAX_WRITE-1:0] hit;
  win_t                 win;

  always_comb begin
    hit = '0;
    for (int unsigned w = 0; w < NUM_WRITE; w++) begin
      hit[w] = wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == addr);
    end
    win = win_port(hit);
    fwd = stored;
    for (int unsigned w = 0; w < NUM_WRITE; w++) begin
      if (win.hit && (win.idx == WPORT_W'(w))) fwd = wr_data[w*DATA_W +: DATA_W];
    end
  end
`else
  assign fwd = stored;
`endif

  assign data = (!running || (addr == '0)) ? '0 : fwd;

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised register file: NUM_READ combinational read ports, NUM_WRITE
// synchronous write ports, register 0 hardwired to zero. After reset a sweep
// clears the array one entry per clock, so storage needs no per-entry reset.
// Ports:
//   clk, rstN  - clock (rising edge), asynchronous active-low reset
//   readReg    - NUM_READ packed read addresses, readData - packed read data
//   regWrite   - per-port write enables, writeReg/writeData - packed write ports
//   ready      - high once the clear sweep has completed
// Macro REGFILE_BYPASS_EN: write-to-read forwarding in RUN.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned ADDR_W    = $clog2(DEPTH),
  parameter int unsigned NUM_READ  = 2,
  parameter int unsigned NUM_WRITE = 1
) (
  input  logic                        clk,
  input  logic                        rstN,
  input  logic [NUM_READ*ADDR_W-1:0]  readReg,
  output logic [NUM_READ*DATA_W-1:0]  readData,
  input  logic [NUM_WRITE-1:0]        regWrite,
  input  logic [NUM_WRITE*ADDR_W-1:0] writeReg,
  input  logic [NUM_WRITE*DATA_W-1:0] writeData,
  output logic                        ready
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("regfile_multiport: DEPTH must be a power of two and at least 2");
  end
  if (ADDR_W != $clog2(DEPTH)) begin : g_bad_addr_w
    $error("regfile_multiport: ADDR_W must equal clog2(DEPTH)");
  end
  if ((NUM_READ < 1) || (NUM_READ > MAX_READ)) begin : g_bad_num_read
    $error("regfile_multiport: NUM_READ must be 1..4");
  end
  if ((NUM_WRITE < 1) || (NUM_WRITE > MAX_WRITE)) begin : g_bad_num_write
    $error("regfile_multiport: NUM_WRITE must be 1..2");
  end

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clearIdx;
  logic [DATA_W-1:0] mem [DEPTH];

  // ready mirrors the registered state, so it rises on the edge that
  // retires the final sweep write.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= INIT;
      clearIdx <= '0;
      ready    <= 1'b0;
    end else begin
      state <= state_nxt;
      ready <= (state_nxt == RUN);
      if (state == INIT) clearIdx <= clearIdx + ADDR_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (clearIdx == ADDR_W'(DEPTH - 1)) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  // No reset on the array. Later loop iterations override earlier ones,
  // giving the highest-numbered port priority on a collision.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[clearIdx] <= '0;
    end else begin
      for (int unsigned w = 0; w < NUM_WRITE; w++) begin
        if (regWrite[w] && (writeReg[w*ADDR_W +: ADDR_W] != '0)) begin
          mem[writeReg[w*ADDR_W +: ADDR_W]] <= writeData[w*DATA_W +: DATA_W];
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    regfile_read_port #(
      .DATA_W    (DATA_W),
`ifdef REGFILE_BYPASS_EN
      .NUM_WRITE (NUM_WRITE),
`endif
      .ADDR_W    (ADDR_W)
    ) u_rd (
      .running (ready),
      .addr    (readReg[i*ADDR_W +: ADDR_W]),
      .stored  (mem[readReg[i*ADDR_W +: ADDR_W]]),
`ifdef REGFILE_BYPASS_EN
      .wr_en   (regWrite),
      .wr_addr (writeReg),
      .wr_data (writeData),
`endif
      .data    (readData[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport (two read ports, two write ports).
module tb_regfile_multiport;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rstN;
  logic [NR*AW-1:0] readReg;
  logic [NR*DW-1:0] readData;
  logic [NW-1:0]    regWrite;
  logic [NW*AW-1:0] writeReg;
  logic [NW*DW-1:0] writeData;
  logic             ready;

  regfile_multiport #(
    .DATA_W    (DW),
    .DEPTH     (32),
    .NUM_READ  (NR),
    .NUM_WRITE (NW)
  ) dut (
    .clk       (clk),
    .rstN      (rstN),
    .readReg   (readReg),
    .readData  (readData),
    .regWrite  (regWrite),
    .writeReg  (writeReg),
    .writeData (writeData),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          kind;   // 0: ready, 1: readData port
    int          port;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  exp_t        mon_e;
  logic [31:0] mon_act;

  // Monitor: compares every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc == cyc) begin
      mon_e = q.pop_front();
      checks++;
      if (mon_e.kind == 0) mon_act = {31'b0, ready};
      else                 mon_act = readData[mon_e.port*DW +: DW];
      if (mon_act !== mon_e.val) begin
        errors++;
        $display("FAIL %s (cycle %0d): got %h, expected %h", mon_e.name, cyc, mon_act, mon_e.val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    regWrite[p]           = 1'b1;
    writeReg[p*AW +: AW]  = a;
    writeData[p*DW +: DW] = d;
  endtask

  task automatic wr_clr();
    regWrite = '0;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a);
    readReg[p*AW +: AW] = a;
  endtask

  task automatic exp_rd(input int p, input logic [31:0] v, input string n);
    q.push_back('{cyc, 1, p, v, n});
  endtask

  task automatic exp_rdy(input logic v, input string n);
    q.push_back('{cyc, 0, 0, {31'b0, v}, n});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rstN      = 1'b0;
    readReg   = '0;
    regWrite  = '0;
    writeReg  = '0;
    writeData = '0;
    step();

    // Reset held for 3 cycles
    for (int k = 0; k < 3; k++) begin
      rd(0, 5'd5);
      rd(1, 5'd0);
      exp_rdy(1'b0, "rst_ready");
      exp_rd(0, 32'h0, "rst_rd0");
      exp_rd(1, 32'h0, "rst_rd1");
      step();
    end

    // Release: ready stays low for exactly 32 cycles, reads gated to zero
    rstN = 1'b1;
    rd(1, 5'd31);
    exp_rdy(1'b0, "init_ready");
    exp_rd(0, 32'h0, "init_gate0");
    exp_rd(1, 32'h0, "init_gate1");
    step();
    for (int k = 1; k < 32; k++) begin
      exp_rdy(1'b0, "init_ready");
      step();
    end
    exp_rdy(1'b1, "ready_rise");

    // Every register reads zero after the sweep
    for (int a = 0; a < 32; a++) begin
      rd(0, 5'(a));
      rd(1, 5'(31 - a));
      exp_rd(0, 32'h0, "sweep0");
      exp_rd(1, 32'h0, "sweep1");
      step();
    end

    // Basic write/read
    wr(0, 5'd5, 32'hDEADBEEF);
    rd(0, 5'd5);
    rd(1, 5'd5);
    exp_rd(0, BYP ? 32'hDEADBEEF : 32'h0, "wr5_same0");
    exp_rd(1, BYP ? 32'hDEADBEEF : 32'h0, "wr5_same1");
    step();
    wr_clr();
    rd(1, 5'd6);
    exp_rd(0, 32'hDEADBEEF, "wr5_next0");
    exp_rd(1, 32'h0, "rd6_zero");
    step();
    rd(1, 5'd5);
    exp_rd(1, 32'hDEADBEEF, "wr5_next1");
    step();

    // Register 0 stays zero
    wr(0, 5'd0, 32'hFFFFFFFF);
    wr(1, 5'd0, 32'hFFFFFFFF);
    rd(0, 5'd0);
    rd(1, 5'd0);
    exp_rd(0, 32'h0, "zero_same0");
    exp_rd(1, 32'h0, "zero_same1");
    step();
    wr_clr();
    for (int k = 0; k < 2; k++) begin
      exp_rd(0, 32'h0, "zero_after0");
      exp_rd(1, 32'h0, "zero_after1");
      step();
    end

    // Two ports writing distinct registers
    wr(0, 5'd10, 32'hAAAA0000);
    wr(1, 5'd11, 32'h0000BBBB);
    rd(0, 5'd10);
    rd(1, 5'd11);
    exp_rd(0, BYP ? 32'hAAAA0000 : 32'h0, "dual_same0");
    exp_rd(1, BYP ? 32'h0000BBBB : 32'h0, "dual_same1");
    step();
    wr_clr();
    exp_rd(0, 32'hAAAA0000, "dual_next0");
    exp_rd(1, 32'h0000BBBB, "dual_next1");
    step();

    // Collision: highest port wins
    wr(0, 5'd9, 32'h11111111);
    wr(1, 5'd9, 32'h22222222);
    rd(0, 5'd9);
    rd(1, 5'd9);
    exp_rd(0, BYP ? 32'h22222222 : 32'h0, "coll_same0");
    exp_rd(1, BYP ? 32'h22222222 : 32'h0, "coll_same1");
    step();
    wr_clr();
    exp_rd(0, 32'h22222222, "coll_next0");
    exp_rd(1, 32'h22222222, "coll_next1");
    step();

    // Same-cycle read/write of reg 7
    wr(0, 5'd7, 32'hA);
    rd(0, 5'd7);
    rd(1, 5'd5);
    exp_rd(0, BYP ? 32'hA : 32'h0, "r7_first");
    exp_rd(1, 32'hDEADBEEF, "r5_hold");
    step();
    wr_clr();
    wr(1, 5'd7, 32'hB);
    rd(1, 5'd7);
    exp_rd(0, BYP ? 32'hB : 32'hA, "r7_same0");
    exp_rd(1, BYP ? 32'hB : 32'hA, "r7_same1");
    step();
    wr_clr();
    exp_rd(0, 32'hB, "r7_next0");
    exp_rd(1, 32'hB, "r7_next1");
    step();

    // Mid-operation reset
    wr(0, 5'd3, 32'h1234);
    step();
    wr_clr();
    rd(0, 5'd3);
    rd(1, 5'd5);
    exp_rd(0, 32'h1234, "r3_before");
    exp_rdy(1'b1, "ready_before");
    step();
    wr(0, 5'd3, 32'hFFFF);
    #2 rstN = 1'b0;
    exp_rdy(1'b0, "async_drop");
    exp_rd(0, 32'h0, "async_rd0");
    exp_rd(1, 32'h0, "async_rd1");
    step();
    exp_rdy(1'b0, "rst_hold");
    step();
    rstN = 1'b1;
    wr(1, 5'd4, 32'h5555);
    rd(1, 5'd4);
    exp_rdy(1'b0, "init2_ready");
    exp_rd(0, 32'h0, "init2_rd0");
    exp_rd(1, 32'h0, "init2_rd1");
    step();
    for (int k = 1; k < 32; k++) begin
      if (k == 31) wr_clr();
      exp_rdy(1'b0, "init2_ready");
      step();
    end
    exp_rdy(1'b1, "ready_return");
    exp_rd(0, 32'h0, "r3_cleared");
    exp_rd(1, 32'h0, "r4_ignored");
    step();
    rd(1, 5'd5);
    exp_rd(0, 32'h0, "r3_cleared2");
    exp_rd(1, 32'h0, "r5_cleared");
    step();

    step();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
